// File: rtl/next_hop_select_pkg.sv
`default_nettype none
// ============================================================================
// Module   : next_hop_select_pkg
// Brief    : Shared widths, neighbor-table limits and FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
package next_hop_select_pkg;

    localparam int unsigned c_WORD_WIDTH    = 16;
    localparam int unsigned c_MAX_NEIGHBORS = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } nh_state_t;

endpackage
`default_nettype wire

// File: rtl/next_hop_select_neighbor_compare.sv
`default_nettype none
// ============================================================================
// Module   : neighbor_compare
// Brief    : Decides whether a candidate entry beats the current best entry.
// Revision : 1.0 - initial release
// ============================================================================
module neighbor_compare
    import next_hop_select_pkg::*;
#(
    parameter int WORD_WIDTH = c_WORD_WIDTH
) (
    input  logic [WORD_WIDTH-1:0] cand_q,
    input  logic [WORD_WIDTH-1:0] cand_energy,
    input  logic                  cand_eligible,
    input  logic [WORD_WIDTH-1:0] best_q,
    input  logic [WORD_WIDTH-1:0] best_energy,
    input  logic                  best_valid,
    output logic                  cand_wins
);

    logic w_q_greater;
    logic w_q_equal;
    logic w_energy_greater;

    assign w_q_greater      = cand_q > best_q;
    assign w_q_equal        = cand_q == best_q;
    assign w_energy_greater = cand_energy > best_energy;

    // A full tie keeps the earlier entry, so only a strict win replaces it.
    assign cand_wins = cand_eligible &&
                       (!best_valid || w_q_greater || (w_q_equal && w_energy_greater));

endmodule
`default_nettype wire

// File: rtl/next_hop_select.sv
`default_nettype none
// ============================================================================
// Module   : next_hop_select
// Brief    : Scans the neighbor table and selects the best eligible next hop.
// Revision : 1.0 - initial release
// ============================================================================
module next_hop_select
    import next_hop_select_pkg::*;
#(
    parameter int                    WORD_WIDTH    = c_WORD_WIDTH,
    parameter int                    MAX_NEIGHBORS = c_MAX_NEIGHBORS,
    parameter logic [WORD_WIDTH-1:0] ENERGY_MIN    = '0
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [WORD_WIDTH-1:0] neighborCount,
    input  logic [WORD_WIDTH-1:0] myID,
    output logic [WORD_WIDTH-1:0] rd_index,
    input  logic [WORD_WIDTH-1:0] mSourceID,
    input  logic [WORD_WIDTH-1:0] mEnergyLeft,
    input  logic [WORD_WIDTH-1:0] mQValue,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [WORD_WIDTH-1:0] nextHopID,
    output logic [WORD_WIDTH-1:0] nextHopQ,
    output logic [WORD_WIDTH-1:0] nextHopEnergy
);

    localparam logic [WORD_WIDTH-1:0] c_MAX_COUNT = WORD_WIDTH'(MAX_NEIGHBORS);

    nh_state_t             r_state_q,       w_state_d;
    logic [WORD_WIDTH-1:0] r_last_q,        w_last_d;
    logic [WORD_WIDTH-1:0] r_rd_index_q,    w_rd_index_d;
    logic                  r_busy_q,        w_busy_d;
    logic                  r_done_q,        w_done_d;
    logic                  r_dvalid_q,      w_dvalid_d;
    logic                  r_best_valid_q,  w_best_valid_d;
    logic [WORD_WIDTH-1:0] r_best_id_q,     w_best_id_d;
    logic [WORD_WIDTH-1:0] r_best_qv_q,     w_best_qv_d;
    logic [WORD_WIDTH-1:0] r_best_energy_q, w_best_energy_d;
    logic                  r_found_q,       w_found_d;
    logic [WORD_WIDTH-1:0] r_hop_id_q,      w_hop_id_d;
    logic [WORD_WIDTH-1:0] r_hop_qv_q,      w_hop_qv_d;
    logic [WORD_WIDTH-1:0] r_hop_energy_q,  w_hop_energy_d;

    logic [WORD_WIDTH-1:0] w_count_clamped;
    logic [WORD_WIDTH:0]   w_energy_diff;
    logic                  w_cand_eligible;
    logic                  w_cand_wins;
    logic                  w_run_valid;
    logic [WORD_WIDTH-1:0] w_run_id;
    logic [WORD_WIDTH-1:0] w_run_qv;
    logic [WORD_WIDTH-1:0] w_run_energy;

    assign w_count_clamped = (neighborCount > c_MAX_COUNT) ? c_MAX_COUNT : neighborCount;

    // Borrow bit of the extended subtraction is set exactly when energy < ENERGY_MIN.
    assign w_energy_diff   = {1'b0, mEnergyLeft} - {1'b0, ENERGY_MIN};
    assign w_cand_eligible = r_dvalid_q && !w_energy_diff[WORD_WIDTH] && (mSourceID != myID);

    neighbor_compare #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_neighbor_compare (
        .cand_q        (mQValue),
        .cand_energy   (mEnergyLeft),
        .cand_eligible (w_cand_eligible),
        .best_q        (r_best_qv_q),
        .best_energy   (r_best_energy_q),
        .best_valid    (r_best_valid_q),
        .cand_wins     (w_cand_wins)
    );

    assign w_run_valid  = r_best_valid_q | w_cand_wins;
    assign w_run_id     = w_cand_wins ? mSourceID   : r_best_id_q;
    assign w_run_qv     = w_cand_wins ? mQValue     : r_best_qv_q;
    assign w_run_energy = w_cand_wins ? mEnergyLeft : r_best_energy_q;

    always_comb begin
        w_state_d       = r_state_q;
        w_last_d        = r_last_q;
        w_rd_index_d    = r_rd_index_q;
        w_busy_d        = r_busy_q;
        w_done_d        = 1'b0;
        w_dvalid_d      = 1'b0;
        w_best_valid_d  = w_run_valid;
        w_best_id_d     = w_run_id;
        w_best_qv_d     = w_run_qv;
        w_best_energy_d = w_run_energy;
        w_found_d       = r_found_q;
        w_hop_id_d      = r_hop_id_q;
        w_hop_qv_d      = r_hop_qv_q;
        w_hop_energy_d  = r_hop_energy_q;

        case (r_state_q)
            ST_IDLE: begin
                if (en) begin
                    w_best_valid_d  = 1'b0;
                    w_best_id_d     = '0;
                    w_best_qv_d     = '0;
                    w_best_energy_d = '0;
                    if (w_count_clamped == '0) begin
                        w_state_d      = ST_DONE;
                        w_done_d       = 1'b1;
                        w_found_d      = 1'b0;
                        w_hop_id_d     = '0;
                        w_hop_qv_d     = '0;
                        w_hop_energy_d = '0;
                    end else begin
                        w_state_d    = ST_SCAN;
                        w_rd_index_d = '0;
                        w_last_d     = w_count_clamped - 1'b1;
                        w_busy_d     = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                w_dvalid_d = 1'b1;
                if (r_rd_index_q == r_last_q) begin
                    w_state_d = ST_DRAIN;
                end else begin
                    w_rd_index_d = r_rd_index_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // The last entry's data is compared this cycle, so publish the running result.
                w_state_d      = ST_DONE;
                w_done_d       = 1'b1;
                w_busy_d       = 1'b0;
                w_found_d      = w_run_valid;
                w_hop_id_d     = w_run_id;
                w_hop_qv_d     = w_run_qv;
                w_hop_energy_d = w_run_energy;
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            r_state_q       <= ST_IDLE;
            r_last_q        <= '0;
            r_rd_index_q    <= '0;
            r_busy_q        <= 1'b0;
            r_done_q        <= 1'b0;
            r_dvalid_q      <= 1'b0;
            r_best_valid_q  <= 1'b0;
            r_best_id_q     <= '0;
            r_best_qv_q     <= '0;
            r_best_energy_q <= '0;
            r_found_q       <= 1'b0;
            r_hop_id_q      <= '0;
            r_hop_qv_q      <= '0;
            r_hop_energy_q  <= '0;
        end else begin
            r_state_q       <= w_state_d;
            r_last_q        <= w_last_d;
            r_rd_index_q    <= w_rd_index_d;
            r_busy_q        <= w_busy_d;
            r_done_q        <= w_done_d;
            r_dvalid_q      <= w_dvalid_d;
            r_best_valid_q  <= w_best_valid_d;
            r_best_id_q     <= w_best_id_d;
            r_best_qv_q     <= w_best_qv_d;
            r_best_energy_q <= w_best_energy_d;
            r_found_q       <= w_found_d;
            r_hop_id_q      <= w_hop_id_d;
            r_hop_qv_q      <= w_hop_qv_d;
            r_hop_energy_q  <= w_hop_energy_d;
        end
    end

    assign rd_index      = r_rd_index_q;
    assign busy          = r_busy_q;
    assign done          = r_done_q;
    assign found         = r_found_q;
    assign nextHopID     = r_hop_id_q;
    assign nextHopQ      = r_hop_qv_q;
    assign nextHopEnergy = r_hop_energy_q;

endmodule
`default_nettype wire

// File: tb/tb_next_hop_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_next_hop_select
// Brief    : Scoreboard bench for next_hop_select with a registered table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_next_hop_select;

    localparam int W = 16;

    logic                clk = 1'b0;
    logic                nrst;
    logic [1:0]          en;
    logic [W-1:0]        neighbor_count;
    logic [W-1:0]        my_id;
    logic [1:0][W-1:0]   rd_idx;
    logic [1:0][W-1:0]   m_sid;
    logic [1:0][W-1:0]   m_e;
    logic [1:0][W-1:0]   m_q;
    logic [1:0]          busy_o;
    logic [1:0]          done_o;
    logic [1:0]          found_o;
    logic [1:0][W-1:0]   hop_id;
    logic [1:0][W-1:0]   hop_q;
    logic [1:0][W-1:0]   hop_e;

    logic [W-1:0] tbl_id [256];
    logic [W-1:0] tbl_q  [256];
    logic [W-1:0] tbl_e  [256];

    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    next_hop_select #(.WORD_WIDTH(W), .MAX_NEIGHBORS(256), .ENERGY_MIN(16'd0)) dut0 (
        .clk(clk), .nrst(nrst), .en(en[0]), .neighborCount(neighbor_count), .myID(my_id),
        .rd_index(rd_idx[0]), .mSourceID(m_sid[0]), .mEnergyLeft(m_e[0]), .mQValue(m_q[0]),
        .busy(busy_o[0]), .done(done_o[0]), .found(found_o[0]),
        .nextHopID(hop_id[0]), .nextHopQ(hop_q[0]), .nextHopEnergy(hop_e[0])
    );

    next_hop_select #(.WORD_WIDTH(W), .MAX_NEIGHBORS(256), .ENERGY_MIN(16'd8)) dut1 (
        .clk(clk), .nrst(nrst), .en(en[1]), .neighborCount(neighbor_count), .myID(my_id),
        .rd_index(rd_idx[1]), .mSourceID(m_sid[1]), .mEnergyLeft(m_e[1]), .mQValue(m_q[1]),
        .busy(busy_o[1]), .done(done_o[1]), .found(found_o[1]),
        .nextHopID(hop_id[1]), .nextHopQ(hop_q[1]), .nextHopEnergy(hop_e[1])
    );

    // Neighbor table: one-cycle registered read per DUT
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_sid[k] <= tbl_id[rd_idx[k][7:0]];
            m_e[k]   <= tbl_e[rd_idx[k][7:0]];
            m_q[k]   <= tbl_q[rd_idx[k][7:0]];
        end
    end

    typedef struct {
        int          sel;
        int          cyc;
        logic        found;
        logic [W-1:0] id;
        logic [W-1:0] q;
        logic [W-1:0] e;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   busy_total[2] = '{0, 0};
    logic [W-1:0] last_busy_idx[2];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin : monitor
        exp_t x;
        for (int k = 0; k < 2; k++) begin
            if (busy_o[k] === 1'b1) begin
                busy_total[k]++;
                last_busy_idx[k] = rd_idx[k];
            end
            if (done_o[k] !== 1'b0) begin
                if (sbq.size() == 0) begin
                    chk($sformatf("unexpected_done_dut%0d", k), 32'(done_o[k]), 32'd0);
                end else begin
                    x = sbq.pop_front();
                    chk({x.name, "_dut"},    k,                 x.sel);
                    chk({x.name, "_cycle"},  cyc,               x.cyc);
                    chk({x.name, "_found"},  32'(found_o[k]),   32'(x.found));
                    chk({x.name, "_id"},     32'(hop_id[k]),    32'(x.id));
                    chk({x.name, "_q"},      32'(hop_q[k]),     32'(x.q));
                    chk({x.name, "_energy"}, 32'(hop_e[k]),     32'(x.e));
                end
            end
        end
    end

    task automatic set_entry(input int i, input logic [W-1:0] id, input logic [W-1:0] q,
                             input logic [W-1:0] e);
        tbl_id[i] = id;
        tbl_q[i]  = q;
        tbl_e[i]  = e;
    endtask

    task automatic wait_empty(input int limit);
        int g = 0;
        while (sbq.size() != 0 && g < limit) begin
            @(posedge clk);
            g++;
        end
        if (sbq.size() != 0) begin
            chk("timeout_pending_done", sbq.size(), 0);
            sbq.delete();
        end
    endtask

    // Caller is positioned just after a falling edge; en is raised immediately.
    task automatic run(input string name, input int sel, input int cnt, input int n_eff,
                       input int extra_en, input logic f, input logic [W-1:0] id,
                       input logic [W-1:0] q, input logic [W-1:0] e);
        exp_t x;
        int   b0;
        b0 = busy_total[sel];
        neighbor_count = W'(cnt);
        en[sel] = 1'b1;
        x.sel = sel;
        x.cyc = cyc + n_eff + ((n_eff == 0) ? 1 : 2);
        x.found = f;
        x.id = id;
        x.q = q;
        x.e = e;
        x.name = name;
        sbq.push_back(x);
        @(negedge clk);
        en[sel] = 1'b0;
        neighbor_count = 16'd7;
        if (extra_en > 0) begin
            repeat (extra_en) @(negedge clk);
            en[sel] = 1'b1;
            @(negedge clk);
            en[sel] = 1'b0;
        end
        wait_empty(n_eff + 20);
        repeat (3) @(negedge clk);
        chk({name, "_hold_found"}, 32'(found_o[sel]), 32'(f));
        chk({name, "_hold_id"}, 32'(hop_id[sel]), 32'(id));
        chk({name, "_busy_cycles"}, busy_total[sel] - b0, (n_eff == 0) ? 0 : n_eff + 1);
    endtask

    task automatic check_zero(input string name, input int k);
        chk({name, "_busy"},   32'(busy_o[k]),  0);
        chk({name, "_done"},   32'(done_o[k]),  0);
        chk({name, "_found"},  32'(found_o[k]), 0);
        chk({name, "_rd"},     32'(rd_idx[k]),  0);
        chk({name, "_id"},     32'(hop_id[k]),  0);
        chk({name, "_q"},      32'(hop_q[k]),   0);
        chk({name, "_energy"}, 32'(hop_e[k]),   0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        nrst = 1'b1;
        en = 2'b00;
        neighbor_count = '0;
        my_id = 16'd1;
        for (int i = 0; i < 256; i++) set_entry(i, 16'd0, 16'd0, 16'd0);
        repeat (3) @(negedge clk);
        check_zero("reset_dut0", 0);
        check_zero("reset_dut1", 1);

        // Empty table immediately after reset release
        nrst = 1'b0;
        run("n0", 0, 0, 0, 0, 1'b0, 16'd0, 16'd0, 16'd0);
        chk("n0_rd_index", 32'(rd_idx[0]), 0);

        @(negedge clk);
        set_entry(0, 16'd2, 16'd10, 16'd5);
        set_entry(1, 16'd3, 16'd40, 16'd3);
        set_entry(2, 16'd4, 16'd25, 16'd9);
        set_entry(3, 16'd5, 16'd40, 16'd7);
        run("basic4", 0, 4, 4, 0, 1'b1, 16'd5, 16'd40, 16'd7);

        @(negedge clk);
        set_entry(0, 16'd7, 16'd50, 16'd2);
        set_entry(1, 16'd8, 16'd5,  16'd9);
        set_entry(2, 16'd9, 16'd5,  16'd8);
        run("emin_pick", 1, 3, 3, 0, 1'b1, 16'd8, 16'd5, 16'd9);

        @(negedge clk);
        set_entry(0, 16'd2, 16'd30, 16'd2);
        set_entry(1, 16'd3, 16'd20, 16'd4);
        set_entry(2, 16'd4, 16'd10, 16'd7);
        run("emin_none", 1, 3, 3, 0, 1'b0, 16'd0, 16'd0, 16'd0);

        @(negedge clk);
        for (int i = 0; i < 3; i++) set_entry(i, 16'd1, 16'd60, 16'd9);
        run("self_only", 1, 3, 3, 0, 1'b0, 16'd0, 16'd0, 16'd0);

        @(negedge clk);
        for (int i = 0; i < 3; i++) set_entry(i, 16'(11 + i), 16'd20, 16'd6);
        run("full_tie", 0, 3, 3, 1, 1'b1, 16'd11, 16'd20, 16'd6);

        @(negedge clk);
        for (int i = 0; i < 4; i++) set_entry(i, 16'(21 + i), 16'(1 + i), 16'd100);
        set_entry(4, 16'd25, 16'hFFFF, 16'd0);
        run("max_q_last", 0, 5, 5, 0, 1'b1, 16'd25, 16'hFFFF, 16'd0);

        @(negedge clk);
        set_entry(0, 16'd31, 16'd9,  16'd1);
        set_entry(1, 16'd1,  16'd70, 16'd50);
        set_entry(2, 16'd32, 16'd70, 16'd50);
        set_entry(3, 16'd33, 16'd8,  16'd1);
        run("skip_self", 0, 4, 4, 0, 1'b1, 16'd32, 16'd70, 16'd50);

        @(negedge clk);
        for (int i = 0; i < 256; i++) set_entry(i, 16'(1000 + i), 16'(i), 16'd1);
        run("clamp300", 0, 300, 256, 0, 1'b1, 16'd1255, 16'd255, 16'd1);
        chk("clamp300_last_index", 32'(last_busy_idx[0]), 255);

        // Abort a long scan with reset at index 10
        @(negedge clk);
        neighbor_count = 16'd300;
        en[0] = 1'b1;
        @(negedge clk);
        en[0] = 1'b0;
        g = 0;
        while (rd_idx[0] != 16'd10 && g < 400) begin
            @(negedge clk);
            g++;
        end
        chk("mid_reset_reach_idx10", 32'(rd_idx[0]), 10);
        nrst = 1'b1;
        @(negedge clk);
        check_zero("mid_reset", 0);

        nrst = 1'b0;
        set_entry(0, 16'd2, 16'd10, 16'd5);
        set_entry(1, 16'd3, 16'd40, 16'd3);
        set_entry(2, 16'd4, 16'd25, 16'd9);
        set_entry(3, 16'd5, 16'd40, 16'd7);
        run("after_reset", 0, 4, 4, 0, 1'b1, 16'd5, 16'd40, 16'd7);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/next_hop_select.md
NEXT_HOP_SELECT -- requirements
Module: next_hop_select

Interface
REQ-001 Parameter WORD_WIDTH, 16, width of every ID/energy/Q/count word.
REQ-002 Parameter MAX_NEIGHBORS, 256, upper clamp on entries scanned.
REQ-003 Parameter ENERGY_MIN, 16'd0, entries with energy below this are ineligible.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 nrst  in  1  reset, synchronous, active-high.
REQ-006 en  in  1  start request, sampled only in IDLE.
REQ-007 neighborCount  in  WORD_WIDTH  number of valid neighbor-table entries, from the Q-table update stage.
REQ-008 myID  in  WORD_WIDTH  own node ID; matching entries are ineligible.
REQ-009 rd_index  out  WORD_WIDTH  neighbor-table read address.
REQ-010 mSourceID, mEnergyLeft, mQValue  in  WORD_WIDTH each  table read data, valid one cycle after rd_index.
REQ-011 busy  out  1  high from the cycle after start until done.
REQ-012 done  out  1  single-cycle completion pulse.
REQ-013 found  out  1  at least one eligible entry existed.
REQ-014 nextHopID, nextHopQ, nextHopEnergy  out  WORD_WIDTH each  selected entry fields.

Function
REQ-015 FSM states IDLE, SCAN, DRAIN, DONE; IDLE->SCAN on en=1; SCAN->DRAIN after the last index is issued; DRAIN->DONE; DONE->IDLE unconditionally.
REQ-016 On start, count N = min(neighborCount, MAX_NEIGHBORS) is latched; later neighborCount changes do not affect the scan.
REQ-017 If N=0, the FSM goes IDLE->DONE directly; done pulses at start cycle +1 with found=0.
REQ-018 For N>0, rd_index = 0..N-1 on consecutive SCAN cycles; en sampled at cycle t gives rd_index 0 at t+1, last data at t+N+1 (DRAIN), done at t+N+2.
REQ-019 Entry is eligible iff mEnergyLeft >= ENERGY_MIN and mSourceID != myID.
REQ-020 Selection: highest mQValue (unsigned); tie -> higher mEnergyLeft; full tie -> lowest index (first seen kept).
REQ-021 Running best is cleared at start; outputs nextHop*/found are registered and update only in the DONE cycle, then hold until the next DONE.
REQ-022 If no entry is eligible, found=0 and nextHopID/Q/Energy=0 at DONE.
REQ-023 en while busy or in DONE is ignored; no queued restart.
REQ-024 rd_index holds its last value outside SCAN (0 after reset).
REQ-025 N=MAX_NEIGHBORS scans exactly indices 0..MAX_NEIGHBORS-1; the index counter never wraps.

Reset
REQ-026 nrst=1 at a rising edge forces IDLE and busy=0, done=0, found=0, rd_index=0, nextHopID=nextHopQ=nextHopEnergy=0 and clears the running best.
REQ-027 Reset mid-scan aborts without a done pulse; en in the first cycle after reset release is honoured.

Structure
REQ-028 WORD_WIDTH default, FSM state encoding and the MAX_NEIGHBORS default live in the shared package used by the Q-table update stage.
REQ-029 One combinational sub-module, neighbor_compare, takes candidate and current-best (Q, energy, eligible) and returns "candidate wins"; it is instantiated once.

Verification
REQ-030 Bench models the neighbor table as 1-cycle-latency registered memories.
REQ-031 N=4, Q={10,40,25,40}, energy={5,3,9,7}, IDs={2,3,4,5}, myID=1 -> done at t+6, found=1, nextHopID=5, Q=40, energy=7.
REQ-032 neighborCount=0 with en -> done at t+1, found=0, outputs 0, rd_index unchanged at 0.
REQ-033 ENERGY_MIN=8, N=3, energy={2,4,7} -> found=0, all nextHop outputs 0; and with IDs={1,1,1}, myID=1, energy={9,9,9} -> found=0.
REQ-034 N=3, all entries Q=20, energy=6 -> nextHopID = ID at index 0; en pulsed during SCAN has no effect and no second done.
REQ-035 neighborCount=300 -> exactly 256 indices issued (0..255), done at t+258; then nrst asserted at scan index 10 of a new run -> IDLE next cycle, no done, outputs all 0.
